// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
// Requester-side bundle for sram_arbiter: port 0 (video refill reads) and port 1 (host read/write).
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 48
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rdata, p0_rvalid, p1_gnt, p1_rdata, p1_rvalid
  );

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rdata, p0_rvalid, p1_gnt, p1_rdata, p1_rvalid
  );
endinterface

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter for one asynchronous SRAM: sequences strobes with wait states,
// owns the dq tristate and bounds port-1 starvation behind port-0 bursts.
module sram_arbiter #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 48,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_WAIT  = 2,
  parameter int unsigned P0_BURST = 8
) (
  input  logic              clk,
  input  logic              rstn,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce,
  output logic              sram_oen,
  output logic              sram_wen
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned BURST_W  = $clog2(P0_BURST + 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_d, oen_d, wen_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic                p0_gnt_c, p1_gnt_c, p1_wins_c;

  // State and all pin-facing outputs are registered; reset drops any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      burst_q     <= '0;
      owner_q     <= 1'b0;
      sram_addr   <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      sram_ce     <= 1'b1;
      sram_oen    <= 1'b1;
      sram_wen    <= 1'b1;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      burst_q     <= burst_d;
      owner_q     <= owner_d;
      sram_addr   <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      sram_ce     <= ce_d;
      sram_oen    <= oen_d;
      sram_wen    <= wen_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  // Arbitration, sequencing and next-cycle strobe values.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    burst_d     = burst_q;
    owner_d     = owner_q;
    addr_d      = sram_addr;
    dq_out_d    = dq_out_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_gnt_c    = 1'b0;
    p1_gnt_c    = 1'b0;
    ce_d        = 1'b1;
    oen_d       = 1'b1;
    wen_d       = 1'b1;
    dq_oe_d     = 1'b0;
    p1_wins_c   = bus.p1_req && (!bus.p0_req || (burst_q == BURST_W'(P0_BURST)));

    case (state_q)
      IDLE: begin
        if (p1_wins_c) begin
          p1_gnt_c = 1'b1;
          burst_d  = '0;
          owner_d  = 1'b1;
          addr_d   = bus.p1_addr;
          wcnt_d   = '0;
          if (bus.p1_we) begin
            dq_out_d = bus.p1_wdata;
            state_d  = WR_SETUP;
          end else begin
            state_d  = RD;
          end
        end else if (bus.p0_req) begin
          p0_gnt_c = 1'b1;
          owner_d  = 1'b0;
          addr_d   = bus.p0_addr;
          wcnt_d   = '0;
          state_d  = RD;
          if (bus.p1_req && (burst_q != BURST_W'(P0_BURST))) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end
      end
      RD: begin
        if (wcnt_q == WAIT_W'(RD_WAIT - 1)) begin
          state_d = IDLE;
          if (owner_q) begin
            p1_rdata_d  = sram_dq;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = sram_dq;
            p0_rvalid_d = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      WR_SETUP: begin
        wcnt_d  = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (wcnt_q == WAIT_W'(WR_WAIT - 1)) begin
          state_d = WR_HOLD;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      WR_HOLD: begin
        state_d     = IDLE;
        p1_rvalid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Starvation counter only tracks bursts while port 1 is actually waiting.
    if (!bus.p1_req) begin
      burst_d = '0;
    end

    // dq is released in IDLE, which gives every read/write turnaround an undriven cycle.
    case (state_d)
      RD: begin
        ce_d  = 1'b0;
        oen_d = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_d    = 1'b0;
        dq_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_d    = 1'b0;
        wen_d   = 1'b0;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_dq       = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
  assign bus.p0_gnt    = p0_gnt_c;
  assign bus.p1_gnt    = p1_gnt_c;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Bench for sram_arbiter: SRAM device model on the pins, transaction-level reference model,
// directed scenarios plus randomized two-port traffic.
module tb_sram_arbiter;
  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned DATA_W   = 48;
  localparam int unsigned RD_WAIT  = 2;
  localparam int unsigned WR_WAIT  = 2;
  localparam int unsigned P0_BURST = 8;

  logic              clk;
  logic              rstn;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_dq;
  logic              sram_ce, sram_oen, sram_wen;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
                 .WR_WAIT(WR_WAIT), .P0_BURST(P0_BURST)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce(sram_ce), .sram_oen(sram_oen), .sram_wen(sram_wen));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return {8'hA5, a, a};
  endfunction

  // Asynchronous SRAM device: drives dq while selected with oen low, stores on wen rising.
  logic [DATA_W-1:0] dev_mem [bit [ADDR_W-1:0]];
  logic [DATA_W-1:0] dev_rd = '0;
  logic [DATA_W-1:0] lat_data = '0;
  logic [ADDR_W-1:0] lat_addr = '0;
  bit                lat_valid = 1'b0;

  assign sram_dq = (!sram_ce && !sram_oen) ? dev_rd : {DATA_W{1'bz}};

  always @(negedge clk) begin
    dev_rd = dev_mem.exists(sram_addr) ? dev_mem[sram_addr] : init_word(sram_addr);
    if (!sram_ce && !sram_wen) begin
      lat_data  = sram_dq;
      lat_addr  = sram_addr;
      lat_valid = 1'b1;
    end
  end

  always @(posedge sram_wen) begin
    if (lat_valid) dev_mem[lat_addr] = lat_data;
    lat_valid = 1'b0;
  end

  // Reference model: one access at a time, timing derived from grant cycle and wait counts.
  logic [DATA_W-1:0] ref_mem [bit [ADDR_W-1:0]];
  int                cyc = 0;
  bit                acc_v = 1'b0;
  int                acc_g, acc_lat;
  bit                acc_we, acc_port;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  int                m_burst = 0;
  logic [DATA_W-1:0] exp_rd0 = '0, exp_rd1 = '0;
  bit                prev_ra = 1'b0, prev_wa = 1'b0;
  int                m_d;
  bit                e_ce, e_oen, e_wen, e_dq, cur_ra, cur_wa;
  bit                rv0, rv1, m_free, w0, w1;

  always @(negedge clk) begin
    cyc++;
    cur_ra = !sram_ce && !sram_oen;
    cur_wa = !sram_ce && sram_oen;
    if (!rstn) begin
      acc_v   = 1'b0;
      m_burst = 0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      chk("rst_ce", 64'(sram_ce), 1);
      chk("rst_oen", 64'(sram_oen), 1);
      chk("rst_wen", 64'(sram_wen), 1);
      chk("rst_addr", 64'(sram_addr), 0);
      chk("rst_gnt", 64'({bus.p0_gnt, bus.p1_gnt}), 0);
      chk("rst_rvalid", 64'({bus.p0_rvalid, bus.p1_rvalid}), 0);
    end else begin
      e_ce = 1'b1; e_oen = 1'b1; e_wen = 1'b1; e_dq = 1'b0;
      if (acc_v) begin
        m_d = cyc - acc_g;
        if (!acc_we && m_d >= 1 && m_d <= int'(RD_WAIT)) begin
          e_ce = 1'b0; e_oen = 1'b0;
        end else if (acc_we && m_d >= 1 && m_d <= int'(WR_WAIT) + 2) begin
          e_ce = 1'b0; e_dq = 1'b1;
          if (m_d >= 2 && m_d <= int'(WR_WAIT) + 1) e_wen = 1'b0;
        end
      end
      chk("sram_ce", 64'(sram_ce), 64'(e_ce));
      chk("sram_oen", 64'(sram_oen), 64'(e_oen));
      chk("sram_wen", 64'(sram_wen), 64'(e_wen));
      if (!e_ce) chk("sram_addr", 64'(sram_addr), 64'(acc_addr));
      if (e_dq) chk("sram_dq_write", 64'(sram_dq), 64'(acc_data));
      chk("oen_wen_overlap", 64'(!sram_oen && !sram_wen), 0);
      chk("turnaround", 64'((prev_ra && cur_wa) || (prev_wa && cur_ra)), 0);

      rv0 = acc_v && (cyc == acc_g + acc_lat) && !acc_port;
      rv1 = acc_v && (cyc == acc_g + acc_lat) && acc_port;
      if (rv0) exp_rd0 = acc_data;
      if (rv1 && !acc_we) exp_rd1 = acc_data;
      chk("p0_rvalid", 64'(bus.p0_rvalid), 64'(rv0));
      chk("p1_rvalid", 64'(bus.p1_rvalid), 64'(rv1));
      chk("p0_rdata", 64'(bus.p0_rdata), 64'(exp_rd0));
      chk("p1_rdata", 64'(bus.p1_rdata), 64'(exp_rd1));

      m_free = !acc_v || (cyc >= acc_g + acc_lat);
      w1 = m_free && bus.p1_req && (!bus.p0_req || m_burst == int'(P0_BURST));
      w0 = m_free && bus.p0_req && !w1;
      chk("p0_gnt", 64'(bus.p0_gnt), 64'(w0));
      chk("p1_gnt", 64'(bus.p1_gnt), 64'(w1));
      if (w1) m_burst = 0;
      else if (w0 && bus.p1_req && m_burst < int'(P0_BURST)) m_burst++;
      if (!bus.p1_req) m_burst = 0;
      if (w0 || w1) begin
        acc_v    = 1'b1;
        acc_g    = cyc;
        acc_port = w1;
        acc_we   = w1 && bus.p1_we;
        acc_addr = w1 ? bus.p1_addr : bus.p0_addr;
        acc_lat  = acc_we ? int'(WR_WAIT) + 3 : int'(RD_WAIT) + 1;
        if (acc_we) begin
          acc_data = bus.p1_wdata;
          ref_mem[acc_addr] = bus.p1_wdata;
        end else begin
          acc_data = ref_mem.exists(acc_addr) ? ref_mem[acc_addr] : init_word(acc_addr);
        end
      end
    end
    prev_ra = cur_ra;
    prev_wa = cur_wa;
  end

  task automatic p1_access(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           output int lat, output int wlow, output logic [DATA_W-1:0] rd);
    bit got;
    @(posedge clk); #1;
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.p1_gnt) begin got = 1'b1; break; end
    end
    chk("p1_gnt_seen", 64'(got), 1);
    @(posedge clk); #1 bus.p1_req = 1'b0;
    lat = 0; wlow = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      if (!sram_wen) wlow++;
      if (bus.p1_rvalid) begin got = 1'b1; break; end
    end
    chk("p1_rvalid_seen", 64'(got), 1);
    rd = bus.p1_rdata;
  endtask

  task automatic p0_read(input logic [ADDR_W-1:0] a, output int lat, output logic [DATA_W-1:0] rd);
    bit got;
    @(posedge clk); #1;
    bus.p0_req = 1'b1; bus.p0_addr = a;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.p0_gnt) begin got = 1'b1; break; end
    end
    chk("p0_gnt_seen", 64'(got), 1);
    @(posedge clk); #1 bus.p0_req = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      if (bus.p0_rvalid) begin got = 1'b1; break; end
    end
    chk("p0_rvalid_seen", 64'(got), 1);
    rd = bus.p0_rdata;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, wlow, gap, n, ng, nbad, np1, last, g1c, rv;
    int seq [18];
    bit got, g0, g1;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] sq [$];

    rstn = 1'b0;
    bus.p0_req = 1'b0; bus.p0_addr = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 64'({sram_ce, sram_oen, sram_wen}), 64'h7);
    chk("reset_rdata0", 64'(bus.p0_rdata), 0);
    chk("reset_rdata1", 64'(bus.p1_rdata), 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write then port-0 read of the same word.
    p1_access(1'b1, 20'h00010, 48'h123456789ABC, lat, wlow, rd);
    chk("wr_latency", 64'(lat), 5);
    chk("wr_wen_low_cycles", 64'(wlow), 2);
    p0_read(20'h00010, lat, rd);
    chk("rd_latency", 64'(lat), 3);
    chk("rd_data", 64'(rd), 64'h123456789ABC);

    // Back-to-back port-1 write then read with req held across the grant.
    @(posedge clk); #1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 20'h00200; bus.p1_wdata = 48'hCAFEF00D1234;
    got = 1'b0; gap = 0;
    for (int c = 0; c < 100; c++) begin @(negedge clk); if (bus.p1_gnt) begin got = 1'b1; break; end end
    chk("b2b_wr_gnt_seen", 64'(got), 1);
    @(posedge clk); #1 bus.p1_we = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); gap++;
      if (bus.p1_gnt) begin got = 1'b1; break; end
    end
    chk("b2b_rd_gnt_seen", 64'(got), 1);
    chk("b2b_gap", 64'(gap), 5);
    @(posedge clk); #1 bus.p1_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin @(negedge clk); if (bus.p1_rvalid) begin got = 1'b1; break; end end
    chk("b2b_rd_rvalid_seen", 64'(got), 1);
    chk("b2b_rd_data", 64'(bus.p1_rdata), 64'hCAFEF00D1234);
    repeat (3) @(negedge clk);

    // Both ports requesting continuously: 8 port-0 grants then one port-1 grant.
    @(posedge clk); #1;
    bus.p0_req = 1'b1; bus.p0_addr = 20'h00020;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 20'h00021;
    n = 0;
    for (int c = 0; c < 400 && n < 18; c++) begin
      @(negedge clk);
      if (bus.p0_gnt) begin seq[n] = 0; n++; end
      else if (bus.p1_gnt) begin seq[n] = 1; n++; end
    end
    @(posedge clk); #1 bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    chk("burst_grant_count", 64'(n), 18);
    for (int i = 0; i < n; i++) chk("burst_seq", 64'(seq[i]), 64'((i % 9) == 8));
    repeat (5) @(negedge clk);

    // Port 0 streaming 0x00..0xFF alone.
    @(posedge clk); #1 bus.p0_req = 1'b1; bus.p0_addr = '0;
    ng = 0; nbad = 0; np1 = 0; last = -1;
    sq.delete();
    for (int c = 0; c < 2000 && sq.size() < 256; c++) begin
      @(negedge clk);
      g0 = bus.p0_gnt;
      if (bus.p1_gnt) np1++;
      if (bus.p0_rvalid) sq.push_back(bus.p0_rdata);
      if (g0) begin
        if (last >= 0 && c - last != 3) nbad++;
        last = c; ng++;
      end
      @(posedge clk); #1;
      if (g0) begin
        if (ng == 256) bus.p0_req = 1'b0;
        else bus.p0_addr = ADDR_W'(ng);
      end
    end
    bus.p0_req = 1'b0;
    chk("stream_grants", 64'(ng), 256);
    chk("stream_interval_bad", 64'(nbad), 0);
    chk("stream_p1_gnts", 64'(np1), 0);
    chk("stream_rvalids", 64'(sq.size()), 256);
    for (int i = 0; i < sq.size(); i++)
      chk("stream_data", 64'(sq[i]), (i == 16) ? 64'h123456789ABC : 64'(init_word(ADDR_W'(i))));
    repeat (3) @(negedge clk);

    // Randomized traffic on both ports, including requests withdrawn before grant.
    g1c = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      g0 = bus.p0_gnt; g1 = bus.p1_gnt;
      if (g1) g1c++;
      @(posedge clk); #1;
      if (bus.p0_req && !g0) begin
        if ($urandom_range(15) == 0) bus.p0_req = 1'b0;
      end else begin
        bus.p0_req  = ($urandom_range(3) != 0);
        bus.p0_addr = ADDR_W'($urandom_range(31));
      end
      if (bus.p1_req && !g1) begin
        if ($urandom_range(15) == 0) bus.p1_req = 1'b0;
      end else begin
        bus.p1_req   = ($urandom_range(1) != 0);
        bus.p1_we    = ($urandom_range(1) != 0);
        bus.p1_addr  = ADDR_W'($urandom_range(31));
        bus.p1_wdata = DATA_W'({$urandom, $urandom});
      end
    end
    @(posedge clk); #1 bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    chk("random_p1_served", 64'(g1c > 0), 1);
    repeat (10) @(negedge clk);

    // Reset asserted in the middle of a write pulse.
    @(posedge clk); #1;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 20'h003FF; bus.p1_wdata = 48'h0F0F0F0F0F0F;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin @(negedge clk); if (bus.p1_gnt) begin got = 1'b1; break; end end
    chk("abort_gnt_seen", 64'(got), 1);
    @(posedge clk); #1 bus.p1_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (!sram_wen) begin got = 1'b1; break; end end
    chk("abort_wen_low_seen", 64'(got), 1);
    #2 rstn = 1'b0;
    #1;
    chk("abort_wen_immediate", 64'(sram_wen), 1);
    chk("abort_ce_immediate", 64'(sram_ce), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    rv = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.p1_rvalid) rv++; end
    chk("abort_no_rvalid", 64'(rv), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
